// File: rtl/instruction_decoder.sv
// instruction_decoder: IR register, combinational decode, zero flag; INSTR_CNT_EN adds a saturating retired-instruction counter
module instruction_decoder (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic [7:0] pm_data,
  input  logic       alu_zero,
  output logic [7:0] ir,
  output logic       jmp,
  output logic       jmp_nz,
  output logic [3:0] jmp_addr,
  output logic       dont_jmp,
  output logic [7:0] reg_en,
  output logic [3:0] source_sel,
  output logic [2:0] alu_func,
  output logic       x_sel,
  output logic       y_sel
`ifdef INSTR_CNT_EN
  ,
  output logic [15:0] instr_count
`endif
);
  logic is_load, is_move, is_alu, is_nop;
  always_comb begin
    is_load    = ~ir[7];
    is_move    = ir[7:6] == 2'b10;
    is_alu     = ir[7:5] == 3'b110;
    is_nop     = is_move && (ir[5:3] == ir[2:0]);
    jmp        = ir[7:4] == 4'he;
    jmp_nz     = ir[7:4] == 4'hf;
    jmp_addr   = (ir[7:5] == 3'b111) ? ir[3:0] : 4'h0;
    reg_en     = is_load ? (8'h01 << ir[6:4]) :
                 (is_move && !is_nop) ? (8'h01 << ir[5:3]) :
                 is_alu ? 8'h10 : 8'h00;
    source_sel = is_load ? 4'd8 : is_move ? {1'b0, ir[2:0]} : 4'd0;
    alu_func   = ir[2:0];
    x_sel      = ir[4];
    y_sel      = ir[3];
  end
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      ir       <= 8'h80;
      dont_jmp <= 1'b0;
    end else begin
      ir <= pm_data;
      if (is_alu) dont_jmp <= alu_zero;
    end
  end
`ifdef INSTR_CNT_EN
  always_ff @(posedge clk) begin
    if (sync_reset) instr_count <= 16'h0000;
    else if (!is_nop && instr_count != 16'hffff) instr_count <= instr_count + 16'h0001;
  end
`endif
endmodule

// File: tb/tb_instruction_decoder.sv
// tb_instruction_decoder: randomized and directed checks against a category-level model
module tb_instruction_decoder;
  logic       clk = 1'b0;
  logic       sync_reset;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic [7:0] ir;
  logic       jmp, jmp_nz, dont_jmp, x_sel, y_sel;
  logic [3:0] jmp_addr, source_sel;
  logic [7:0] reg_en;
  logic [2:0] alu_func;
`ifdef INSTR_CNT_EN
  logic [15:0] instr_count;
`endif
  int vecs = 0;
  int errs = 0;
  logic [7:0] mir;
  logic       mflag;
  int unsigned mcnt;

  instruction_decoder dut (
    .clk(clk), .sync_reset(sync_reset), .pm_data(pm_data), .alu_zero(alu_zero),
    .ir(ir), .jmp(jmp), .jmp_nz(jmp_nz), .jmp_addr(jmp_addr), .dont_jmp(dont_jmp),
    .reg_en(reg_en), .source_sel(source_sel), .alu_func(alu_func),
    .x_sel(x_sel), .y_sel(y_sel)
`ifdef INSTR_CNT_EN
    , .instr_count(instr_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit m_nop(input int v);
    return v >= 128 && v < 192 && ((v >> 3) & 7) == (v & 7);
  endfunction
  function automatic bit m_alu(input int v);
    return v >= 192 && v < 224;
  endfunction
  function automatic logic [7:0] m_reg_en(input int v);
    if (v < 128) return 8'(1 << ((v >> 4) & 7));
    if (v < 192) return m_nop(v) ? 8'h00 : 8'(1 << ((v >> 3) & 7));
    if (v < 224) return 8'h10;
    return 8'h00;
  endfunction
  function automatic logic [3:0] m_src(input int v);
    return v < 128 ? 4'd8 : v < 192 ? 4'(v & 7) : 4'd0;
  endfunction
  function automatic logic [20:0] m_out(input int v, input logic f);
    return {m_reg_en(v), m_src(v), v >= 224 && v < 240, v >= 240,
            v >= 224 ? 4'(v & 15) : 4'd0, f, 1'(v >> 4), 1'(v >> 3)};
  endfunction

  task automatic tick(input logic rst, input logic [7:0] pm, input logic az);
    @(negedge clk);
    sync_reset = rst;
    pm_data    = pm;
    alu_zero   = az;
    @(posedge clk);
    if (rst) begin
      mir = 8'h80; mflag = 1'b0; mcnt = 0;
    end else begin
      if (m_alu(int'(mir))) mflag = az;
      if (!m_nop(int'(mir)) && mcnt < 65535) mcnt++;
      mir = pm;
    end
    #1;
  endtask

  task automatic test_reset;
    tick(1'b1, 8'he5, 1'b1);
    tick(1'b1, 8'he5, 1'b1);
    vecs++;
    if ({ir, reg_en, jmp, jmp_nz, dont_jmp, source_sel, alu_func} !== {8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, 3'h0}) begin
      errs++;
      $display("FAIL reset: ir=%h reg_en=%h jmp=%b jmp_nz=%b dont_jmp=%b src=%h alu_func=%h, expected ir=80 others 0", ir, reg_en, jmp, jmp_nz, dont_jmp, source_sel, alu_func);
    end
  endtask

  task automatic test_load;
    tick(1'b0, 8'h27, 1'b0);
    vecs++;
    if ({ir, reg_en, source_sel} !== {8'h27, 8'h04, 4'd8}) begin
      errs++;
      $display("FAIL load: ir=%h reg_en=%h src=%h, expected 27 04 8", ir, reg_en, source_sel);
    end
  endtask

  task automatic test_move;
    tick(1'b0, 8'h9a, 1'b0);
    vecs++;
    if ({reg_en, source_sel} !== {8'h08, 4'd2}) begin
      errs++;
      $display("FAIL move: reg_en=%h src=%h, expected 08 2", reg_en, source_sel);
    end
    tick(1'b0, 8'ha4, 1'b0);
    vecs++;
    if (reg_en !== 8'h00) begin
      errs++;
      $display("FAIL nop: reg_en=%h, expected 00", reg_en);
    end
  endtask

  task automatic test_flag;
    tick(1'b0, 8'hc1, 1'b0);
    vecs++;
    if ({reg_en, alu_func, source_sel} !== {8'h10, 3'd1, 4'd0}) begin
      errs++;
      $display("FAIL alu: reg_en=%h alu_func=%h src=%h, expected 10 1 0", reg_en, alu_func, source_sel);
    end
    tick(1'b0, 8'hf3, 1'b1);
    vecs++;
    if ({dont_jmp, jmp_nz, jmp, jmp_addr, reg_en} !== {1'b1, 1'b1, 1'b0, 4'd3, 8'h00}) begin
      errs++;
      $display("FAIL flag_set: dont_jmp=%b jmp_nz=%b jmp=%b addr=%h reg_en=%h, expected 1 1 0 3 00", dont_jmp, jmp_nz, jmp, jmp_addr, reg_en);
    end
    tick(1'b0, 8'hc1, 1'b1);
    tick(1'b0, 8'hf3, 1'b0);
    vecs++;
    if ({dont_jmp, jmp_nz, jmp_addr} !== {1'b0, 1'b1, 4'd3}) begin
      errs++;
      $display("FAIL flag_clr: dont_jmp=%b jmp_nz=%b addr=%h, expected 0 1 3", dont_jmp, jmp_nz, jmp_addr);
    end
  endtask

  task automatic test_flag_hold;
    tick(1'b0, 8'hc5, 1'b0);
    tick(1'b0, 8'he9, 1'b1);
    vecs++;
    if ({jmp, jmp_nz, jmp_addr, dont_jmp} !== {1'b1, 1'b0, 4'd9, 1'b1}) begin
      errs++;
      $display("FAIL jmp: jmp=%b jmp_nz=%b addr=%h dont_jmp=%b, expected 1 0 9 1", jmp, jmp_nz, jmp_addr, dont_jmp);
    end
    tick(1'b0, 8'hf2, 1'b0);
    vecs++;
    if ({dont_jmp, jmp_nz, jmp_addr} !== {1'b1, 1'b1, 4'd2}) begin
      errs++;
      $display("FAIL flag_hold: dont_jmp=%b jmp_nz=%b addr=%h, expected 1 1 2", dont_jmp, jmp_nz, jmp_addr);
    end
  endtask

  task automatic test_reset_override;
    tick(1'b0, 8'hd0, 1'b0);
    tick(1'b1, 8'h35, 1'b1);
    vecs++;
    if ({ir, dont_jmp} !== {8'h80, 1'b0}) begin
      errs++;
      $display("FAIL reset_override: ir=%h dont_jmp=%b, expected 80 0", ir, dont_jmp);
    end
    tick(1'b0, 8'h35, 1'b0);
    vecs++;
    if (ir !== 8'h35) begin
      errs++;
      $display("FAIL resume: ir=%h, expected 35", ir);
    end
  endtask

  task automatic test_random;
    logic [20:0] got, exp;
    for (int n = 0; n < 400; n++) begin
      tick($urandom_range(0, 39) == 0, 8'($urandom), 1'($urandom));
      got = {reg_en, source_sel, jmp, jmp_nz, jmp_addr, dont_jmp, x_sel, y_sel};
      exp = m_out(int'(mir), mflag);
      vecs++;
      if (ir !== mir || got !== exp || (m_alu(int'(mir)) && alu_func !== mir[2:0])) begin
        errs++;
        $display("FAIL random[%0d]: ir=%h dec=%h alu_func=%h, expected ir=%h dec=%h", n, ir, got, alu_func, mir, exp);
      end
`ifdef INSTR_CNT_EN
      vecs++;
      if (instr_count !== 16'(mcnt)) begin
        errs++;
        $display("FAIL random_count[%0d]: instr_count=%0d, expected %0d", n, instr_count, mcnt);
      end
`endif
    end
  endtask

`ifdef INSTR_CNT_EN
  task automatic test_count;
    tick(1'b1, 8'h00, 1'b0);
    for (int n = 0; n < 5; n++) tick(1'b0, 8'h11 + 8'(n), 1'b0);
    tick(1'b0, 8'h80, 1'b0);
    tick(1'b0, 8'h80, 1'b0);
    vecs++;
    if (instr_count !== 16'd5) begin
      errs++;
      $display("FAIL count5: instr_count=%0d, expected 5", instr_count);
    end
    for (int n = 0; n < 65540; n++) tick(1'b0, 8'h42, 1'b0);
    vecs++;
    if (instr_count !== 16'hffff) begin
      errs++;
      $display("FAIL count_sat: instr_count=%h, expected ffff", instr_count);
    end
  endtask
`endif

  initial begin
    mir = 8'h80; mflag = 1'b0; mcnt = 0;
    test_reset();
    test_load();
    test_move();
    test_flag();
    test_flag_hold();
    test_reset_override();
    test_random();
`ifdef INSTR_CNT_EN
    test_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
